du_clk_ctrl: RTL and testbench
==============================

DU_CLK_CTRL -- requirements
Module: du_clk_ctrl

Interface
REQ-001 SHALL have parameter NB_CNT, default 32, width of the cycle counter.
REQ-002 SHALL have parameter STEP_CYCLES, default 1, number of enabled cycles per STEP command (1..255).
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_cmd_valid  input  1  command offered.
REQ-006 SHALL have port i_cmd  input  2  command code: 00 CLEAR, 01 RUN, 10 STEP, 11 HALT.
REQ-007 SHALL have port o_cmd_ready  output  1  command accepted this edge when i_cmd_valid is also high.
REQ-008 SHALL have port i_halt_instr  input  1  pipeline retired the program-end instruction.
REQ-009 SHALL have port o_dunit_clk_en  output  1  pipeline clock enable driven into every stage register.
REQ-010 SHALL have port o_cycle_count  output  NB_CNT  number of enabled cycles since the last CLEAR.
REQ-011 SHALL have port o_state  output  2  encoded FSM state.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-013 SHALL implement states IDLE=00, RUN=01, STEP=10, DONE=11; o_dunit_clk_en SHALL be registered and high exactly in RUN and STEP.
REQ-014 IDLE: o_cmd_ready=1; RUN goes to RUN, STEP goes to STEP with step counter loaded to STEP_CYCLES, CLEAR zeroes o_cycle_count and stays, HALT is accepted with no effect.
REQ-015 RUN: o_cmd_ready=1; HALT goes to IDLE; RUN, STEP and CLEAR are accepted and ignored; i_halt_instr=1 goes to DONE.
REQ-016 STEP: o_cmd_ready=0; step counter decrements each cycle; on reaching 1 the next edge returns to IDLE, giving exactly STEP_CYCLES enabled cycles.
REQ-017 DONE: o_cmd_ready=1; only CLEAR is acted on (to IDLE, count zeroed); all other commands are accepted and ignored.
REQ-018 SHALL sample i_halt_instr only while o_dunit_clk_en=1; in RUN or STEP it goes to DONE on the next edge, overriding any simultaneous command or step expiry.
REQ-019 Latency: a command accepted at edge N SHALL change o_dunit_clk_en in the cycle after edge N.
REQ-020 o_cycle_count SHALL increment by 1 on each edge where o_dunit_clk_en=1 and SHALL saturate at all-ones.
REQ-021 CLEAR in IDLE or DONE SHALL zero the count on the same edge, with no increment that edge.
REQ-022 o_done SHALL be high for exactly the one cycle after the transition into DONE.

Reset
REQ-023 i_reset low SHALL immediately force IDLE, o_dunit_clk_en=0, o_cycle_count=0, step counter=0, o_done=0, including mid-RUN or mid-STEP.
REQ-024 After reset release, the first command SHALL be accepted on the first rising edge.

Configuration
REQ-025 Macro DU_BREAKPOINT_EN: when defined, the block SHALL add ports i_pc (32), i_bp_addr (32) and i_bp_valid (1).
REQ-026 With DU_BREAKPOINT_EN, in RUN, i_bp_valid=1 with i_pc==i_bp_addr SHALL go to IDLE on the next edge; i_halt_instr takes priority.
REQ-027 Without DU_BREAKPOINT_EN, the breakpoint ports and logic SHALL be absent.

Structure
REQ-028 Command codes, state encodings and default NB_CNT SHALL live in shared package du_pkg.
REQ-029 The saturating cycle counter SHALL be sub-module du_sat_counter (enable, clear, count); the FSM stays in du_clk_ctrl.

Verification
REQ-030 Reset low, then release -> o_state=00, o_dunit_clk_en=0, o_cycle_count=0, o_cmd_ready=1.
REQ-031 STEP_CYCLES=1, issue STEP three times -> exactly 3 enabled cycles total, o_cycle_count=3, state back in IDLE.
REQ-032 RUN, HALT after 10 cycles -> clk_en high for 10 cycles, o_cycle_count=10, IDLE; a later RUN resumes counting from 10.
REQ-033 RUN, raise i_halt_instr together with HALT cmd -> DONE, o_done pulses once, subsequent RUN is ignored, CLEAR -> IDLE with count 0.
REQ-034 Assert reset mid-RUN at count 7 -> clk_en=0 and count=0 asynchronously, without waiting for a clock edge.
REQ-035 DU_BREAKPOINT_EN, bp_addr=0x0000_0010, RUN with i_pc stepping by 4 from 0 -> IDLE after the cycle where i_pc=0x10.

Source files
------------

// File: rtl/du_pkg.sv
// Shared definitions for the debug-unit clock controller: command codes,
// FSM state encodings and default widths.
package du_pkg;

  localparam int unsigned DU_NB_CNT = 32;
  localparam int unsigned DU_STEP_W = 8;
  localparam int unsigned DU_PC_W   = 32;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_HALT  = 2'b11
  } du_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } du_state_e;

  // The pipeline clock is enabled exactly in the two executing states
  function automatic logic du_clk_en(input du_state_e st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/du_sat_counter.sv
// Saturating up-counter of enabled pipeline cycles; clear wins over enable.
module du_sat_counter #(
  parameter int unsigned NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_clr,
  output logic [NB_CNT-1:0] o_count
);

  logic [NB_CNT-1:0] count_q;
  logic [NB_CNT-1:0] count_d;

  // Next count: clear, or increment until all-ones
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en && (count_q != {NB_CNT{1'b1}})) begin
      count_d = count_q + NB_CNT'(1);
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/du_clk_ctrl.sv
// Debug-unit clock controller: gates the pipeline clock enable from
// RUN / STEP / HALT / CLEAR commands and counts enabled cycles.
// Optional PC breakpoint support is compiled in with `define DU_BREAKPOINT_EN.
module du_clk_ctrl
  import du_pkg::*;
#(
  parameter int unsigned NB_CNT      = DU_NB_CNT,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_halt_instr,
`ifdef DU_BREAKPOINT_EN
  input  logic [DU_PC_W-1:0] i_pc,
  input  logic [DU_PC_W-1:0] i_bp_addr,
  input  logic               i_bp_valid,
`endif
  output logic               o_dunit_clk_en,
  output logic [NB_CNT-1:0]  o_cycle_count,
  output logic [1:0]         o_state,
  output logic               o_done
);

  du_state_e            state_q;
  du_state_e            state_d;
  logic [DU_STEP_W-1:0] step_q;
  logic [DU_STEP_W-1:0] step_d;
  logic                 clk_en_q;
  logic                 clk_en_d;
  logic                 ready_q;
  logic                 ready_d;
  logic                 done_q;
  logic                 done_d;

  du_cmd_e              cmd_c;
  logic                 cmd_fire_c;
  logic                 halt_hit_c;
  logic                 bp_hit_c;
  logic                 clear_c;

  assign cmd_c      = du_cmd_e'(i_cmd);
  assign cmd_fire_c = i_cmd_valid && ready_q;
  // Program end only counts when the pipeline actually advanced this cycle
  assign halt_hit_c = i_halt_instr && clk_en_q;

`ifdef DU_BREAKPOINT_EN
  assign bp_hit_c = i_bp_valid && (i_pc == i_bp_addr);
`else
  assign bp_hit_c = 1'b0;
`endif

  // State register plus registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      clk_en_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Next-state and step-counter logic; program end overrides everything
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    clear_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          case (cmd_c)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP: begin
              state_d = ST_STEP;
              step_d  = DU_STEP_W'(STEP_CYCLES);
            end
            CMD_CLEAR: clear_c = 1'b1;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (halt_hit_c) begin
          state_d = ST_DONE;
        end else if (bp_hit_c) begin
          state_d = ST_IDLE;
        end else if (cmd_fire_c && (cmd_c == CMD_HALT)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_hit_c) begin
          state_d = ST_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q - DU_STEP_W'(1);
          if (step_q <= DU_STEP_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (cmd_fire_c && (cmd_c == CMD_CLEAR)) begin
          state_d = ST_IDLE;
          clear_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    clk_en_d = du_clk_en(state_d);
    ready_d  = (state_d != ST_STEP);
    done_d   = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  du_sat_counter #(
    .NB_CNT (NB_CNT)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (clk_en_q),
    .i_clr   (clear_c),
    .o_count (o_cycle_count)
  );

  assign o_dunit_clk_en = clk_en_q;
  assign o_cmd_ready    = ready_q;
  assign o_state        = state_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_du_clk_ctrl.sv
// Scoreboard bench for du_clk_ctrl: stimulus pushes expected snapshots,
// a monitor process pops and compares them against the live outputs.
module tb_du_clk_ctrl;
  import du_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v1;
  logic        v2;
  logic [1:0]  cmd;
  logic        halt;

  logic        rdy1, en1, done1;
  logic [31:0] cnt1;
  logic [1:0]  st1;
  logic        rdy2, en2, done2;
  logic [2:0]  cnt2;
  logic [1:0]  st2;

`ifdef DU_BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_valid;
`endif

  always #5 clk = ~clk;

  du_clk_ctrl #(.NB_CNT(32), .STEP_CYCLES(1)) u_dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_cmd_valid    (v1),
    .i_cmd          (cmd),
    .o_cmd_ready    (rdy1),
    .i_halt_instr   (halt),
`ifdef DU_BREAKPOINT_EN
    .i_pc           (pc),
    .i_bp_addr      (bp_addr),
    .i_bp_valid     (bp_valid),
`endif
    .o_dunit_clk_en (en1),
    .o_cycle_count  (cnt1),
    .o_state        (st1),
    .o_done         (done1)
  );

  du_clk_ctrl #(.NB_CNT(3), .STEP_CYCLES(3)) u_dut2 (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_cmd_valid    (v2),
    .i_cmd          (cmd),
    .o_cmd_ready    (rdy2),
    .i_halt_instr   (1'b0),
`ifdef DU_BREAKPOINT_EN
    .i_pc           (pc),
    .i_bp_addr      (bp_addr),
    .i_bp_valid     (1'b0),
`endif
    .o_dunit_clk_en (en2),
    .o_cycle_count  (cnt2),
    .o_state        (st2),
    .o_done         (done2)
  );

  typedef struct {
    int          dut;
    string       name;
    logic [1:0]  st;
    logic        en;
    logic [31:0] cnt;
    logic        rdy;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   en_cyc = 0;
  int   done_pulses = 0;
  int   en_base;
  int   done_base;

  // Independent tally of enabled cycles and done pulses on dut 1
  always @(negedge clk) begin
    if (en1 === 1'b1) en_cyc++;
    if (done1 === 1'b1) done_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop each expected snapshot and compare against the selected DUT
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      if (e.dut == 1) begin
        chk({e.name, ".state"}, 32'(st1),   32'(e.st));
        chk({e.name, ".clken"}, 32'(en1),   32'(e.en));
        chk({e.name, ".count"}, cnt1,       e.cnt);
        chk({e.name, ".ready"}, 32'(rdy1),  32'(e.rdy));
        chk({e.name, ".done"},  32'(done1), 32'(e.dn));
      end else begin
        chk({e.name, ".state"}, 32'(st2),   32'(e.st));
        chk({e.name, ".clken"}, 32'(en2),   32'(e.en));
        chk({e.name, ".count"}, 32'(cnt2),  e.cnt);
        chk({e.name, ".ready"}, 32'(rdy2),  32'(e.rdy));
        chk({e.name, ".done"},  32'(done2), 32'(e.dn));
      end
    end
  end

  task automatic expect_out(input int d, input string n, input logic [1:0] st, input logic en,
                            input logic [31:0] cnt, input logic rdy, input logic dn);
    exp_t e;
    e.dut = d; e.name = n; e.st = st; e.en = en; e.cnt = cnt; e.rdy = rdy; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [1:0] c);
    cmd = c;
    if (d == 1) v1 = 1'b1;
    else        v2 = 1'b1;
    tick();
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; v2 = 1'b0; cmd = 2'b00; halt = 1'b0;
`ifdef DU_BREAKPOINT_EN
    pc = '0; bp_addr = '0; bp_valid = 1'b0;
`endif
    repeat (2) tick();
    expect_out(1, "in_reset", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out(1, "post_reset", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    expect_out(2, "d2_post_reset", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    en_base = en_cyc;

    // Three single-cycle steps
    for (int k = 1; k <= 3; k++) begin
      issue(1, CMD_STEP);
      expect_out(1, $sformatf("step%0d_in", k), 2'b10, 1'b1, 32'(k - 1), 1'b0, 1'b0);
      tick();
      expect_out(1, $sformatf("step%0d_out", k), 2'b00, 1'b0, 32'(k), 1'b1, 1'b0);
    end
    chk("step_enabled_cycles", 32'(en_cyc - en_base), 32'd3);

    issue(1, CMD_CLEAR);
    expect_out(1, "clear_idle", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(1, CMD_HALT);
    expect_out(1, "halt_in_idle", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);

    // RUN for ten enabled cycles, then HALT
    issue(1, CMD_RUN);
    expect_out(1, "run_start", 2'b01, 1'b1, 32'd0, 1'b1, 1'b0);
    repeat (5) tick();
    expect_out(1, "run_mid", 2'b01, 1'b1, 32'd5, 1'b1, 1'b0);
    repeat (4) tick();
    issue(1, CMD_HALT);
    expect_out(1, "run_halt", 2'b00, 1'b0, 32'd10, 1'b1, 1'b0);

    // Resume counts on; CLEAR and STEP are ignored while running
    issue(1, CMD_RUN);
    expect_out(1, "resume", 2'b01, 1'b1, 32'd10, 1'b1, 1'b0);
    issue(1, CMD_CLEAR);
    expect_out(1, "run_clear_ign", 2'b01, 1'b1, 32'd11, 1'b1, 1'b0);
    issue(1, CMD_STEP);
    expect_out(1, "run_step_ign", 2'b01, 1'b1, 32'd12, 1'b1, 1'b0);
    issue(1, CMD_HALT);
    expect_out(1, "resume_halt", 2'b00, 1'b0, 32'd13, 1'b1, 1'b0);

    // Program end together with HALT command goes to DONE
    issue(1, CMD_RUN);
    expect_out(1, "run2_start", 2'b01, 1'b1, 32'd13, 1'b1, 1'b0);
    done_base = done_pulses;
    cmd = CMD_HALT; v1 = 1'b1; halt = 1'b1;
    tick();
    v1 = 1'b0; halt = 1'b0;
    expect_out(1, "halt_instr", 2'b11, 1'b0, 32'd14, 1'b1, 1'b1);
    tick();
    expect_out(1, "done_hold", 2'b11, 1'b0, 32'd14, 1'b1, 1'b0);
    issue(1, CMD_RUN);
    expect_out(1, "done_run_ign", 2'b11, 1'b0, 32'd14, 1'b1, 1'b0);
    issue(1, CMD_STEP);
    expect_out(1, "done_step_ign", 2'b11, 1'b0, 32'd14, 1'b1, 1'b0);
    chk("done_pulse_count", 32'(done_pulses - done_base), 32'd1);
    issue(1, CMD_CLEAR);
    expect_out(1, "done_clear", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);

    // Program end overrides step expiry
    issue(1, CMD_STEP);
    expect_out(1, "step_pre_halt", 2'b10, 1'b1, 32'd0, 1'b0, 1'b0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    expect_out(1, "step_halt", 2'b11, 1'b0, 32'd1, 1'b1, 1'b1);
    issue(1, CMD_CLEAR);
    expect_out(1, "step_halt_clear", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);

    // Program end is ignored while the clock is gated
    halt = 1'b1;
    tick();
    halt = 1'b0;
    expect_out(1, "halt_ign_idle", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN at count 7
    issue(1, CMD_RUN);
    repeat (7) tick();
    expect_out(1, "pre_reset", 2'b01, 1'b1, 32'd7, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out(1, "async_reset", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out(1, "reset_release", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);

`ifdef DU_BREAKPOINT_EN
    // Breakpoint at 0x10 with PC advancing by 4 each enabled cycle
    bp_addr = 32'h0000_0010; bp_valid = 1'b1; pc = '0;
    issue(1, CMD_RUN);
    expect_out(1, "bp_run", 2'b01, 1'b1, 32'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      pc = 32'(4 * i);
    end
    expect_out(1, "bp_before", 2'b01, 1'b1, 32'd4, 1'b1, 1'b0);
    tick();
    expect_out(1, "bp_hit", 2'b00, 1'b0, 32'd5, 1'b1, 1'b0);
    bp_valid = 1'b0;
`endif

    // Second instance: three-cycle STEP, then saturation of a 3-bit count
    issue(2, CMD_STEP);
    expect_out(2, "d2_step_in", 2'b10, 1'b1, 32'd0, 1'b0, 1'b0);
    issue(2, CMD_RUN);
    expect_out(2, "d2_step_busy", 2'b10, 1'b1, 32'd1, 1'b0, 1'b0);
    tick();
    expect_out(2, "d2_step_last", 2'b10, 1'b1, 32'd2, 1'b0, 1'b0);
    tick();
    expect_out(2, "d2_step_done", 2'b00, 1'b0, 32'd3, 1'b1, 1'b0);
    issue(2, CMD_RUN);
    expect_out(2, "d2_run", 2'b01, 1'b1, 32'd3, 1'b1, 1'b0);
    repeat (4) tick();
    expect_out(2, "d2_sat_reach", 2'b01, 1'b1, 32'd7, 1'b1, 1'b0);
    repeat (3) tick();
    expect_out(2, "d2_sat_hold", 2'b01, 1'b1, 32'd7, 1'b1, 1'b0);
    issue(2, CMD_HALT);
    expect_out(2, "d2_halt", 2'b00, 1'b0, 32'd7, 1'b1, 1'b0);
    issue(2, CMD_CLEAR);
    expect_out(2, "d2_clear", 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);

    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
